sort_mem_responder: RTL and testbench

- Memory-side responder for the selection-sort control path.
- Accepts level-held read/write requests, identified by o_rd_en/o_wr_en from the sort controller after address/data muxing.
- Services each request from an internal register array after a programmable latency, then returns a single-cycle i_valid_rd/i_valid_wr-style completion pulse.
- Includes a host load/dump port so the array can be preloaded before a sort and inspected afterwards.

---
 rtl/sort_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_sort_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_mem_responder.sv
// Memory-side responder for the selection-sort controller: register array with a
// programmable-latency request/complete handshake plus a host load/dump port.
// Latency: completion pulse LATENCY cycles after the request-sampling edge; host read data 1 cycle.
// Backpressure: requests are level-held; a new request is accepted only after both enables drop.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_rd_en/i_wr_en              level-held controller requests (write wins when both high)
//   i_addr/i_wr_data             controller address/data, latched in IDLE
//   o_valid_rd/o_valid_wr        one-cycle completion pulses
//   o_rd_data                    read data, held until the next read completion
//   o_busy                       high whenever the FSM is not IDLE
//   o_req_err                    sticky flag for simultaneous read+write request
//   i_host_*/o_host_rdata        host load/dump port, honoured only in IDLE
// Optional: define SORT_MEM_ACC_CNT_EN to add saturating o_rd_cnt/o_wr_cnt
// completion counters (controller accesses only).
module sort_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_valid_rd,
    output logic              o_valid_wr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_req_err,
    input  logic              i_host_en,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
`ifdef SORT_MEM_ACC_CNT_EN
    output logic [15:0]       o_rd_cnt,
    output logic [15:0]       o_wr_cnt,
`endif
    output logic [DATA_W-1:0] o_host_rdata
);

    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_req_err;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_host_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_req;
    logic              w_enter_resp;
    logic              w_cur_wr;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [DATA_W-1:0] w_cur_data;
    logic              w_commit_wr;
    logic              w_host_go;
    logic              w_host_wr;

    assign w_idle       = (r_state == S_IDLE);
    assign w_req        = i_rd_en | i_wr_en;
    // RESP always exits to RELEASE, so a RESP next-state is always an entry edge.
    assign w_enter_resp = (w_state_nxt == S_RESP);

    // With LATENCY==1 the commit happens on the sampling edge itself, before the
    // latches hold the request, so take the live inputs while still in IDLE.
    assign w_cur_wr   = w_idle ? i_wr_en   : r_is_wr;
    assign w_cur_addr = w_idle ? i_addr    : r_addr;
    assign w_cur_data = w_idle ? i_wr_data : r_wdata;

    // The array has no reset, so gate its writes with i_rst_n to keep a reset
    // from committing an aborted write or a stray host strobe.
    assign w_commit_wr = w_enter_resp && w_cur_wr && i_rst_n;
    assign w_host_go   = w_idle && !w_req && i_host_en;
    assign w_host_wr   = w_host_go && i_host_we && i_rst_n;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
                    w_cnt_nxt   = LAT_M1;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!i_rd_en && !i_wr_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_wr      <= 1'b0;
            r_req_err    <= 1'b0;
            r_rd_data    <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_idle && w_req) begin
                r_addr  <= i_addr;
                r_wdata <= i_wr_data;
                r_is_wr <= i_wr_en;
                if (i_rd_en && i_wr_en) begin
                    r_req_err <= 1'b1;
                end
            end
            if (w_enter_resp && !w_cur_wr) begin
                r_rd_data <= r_mem[w_cur_addr];
            end
            if (w_host_go && !i_host_we) begin
                r_host_rdata <= r_mem[i_host_addr];
            end
        end
    end

    // Controller and host writes are mutually exclusive: host access only
    // happens in IDLE with no controller request present.
    always_ff @(posedge i_clk) begin
        if (w_commit_wr) begin
            r_mem[w_cur_addr] <= w_cur_data;
        end else if (w_host_wr) begin
            r_mem[i_host_addr] <= i_host_wdata;
        end
    end

`ifdef SORT_MEM_ACC_CNT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    // Counted on RESP entry so the count moves together with the completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else if (w_enter_resp) begin
            if (w_cur_wr && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (!w_cur_wr && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign o_rd_cnt = r_rd_cnt;
    assign o_wr_cnt = r_wr_cnt;
`endif

    assign o_valid_rd   = (r_state == S_RESP) && !r_is_wr;
    assign o_valid_wr   = (r_state == S_RESP) &&  r_is_wr;
    assign o_busy       = !w_idle;
    assign o_req_err    = r_req_err;
    assign o_rd_data    = r_rd_data;
    assign o_host_rdata = r_host_rdata;

endmodule

// File: tb/tb_sort_mem_responder.sv
// Bench for sort_mem_responder: three instances (LATENCY 2, 1, 4) driven by
// directed vectors, a cycle-stamp transaction model compared every cycle,
// and literal expectations at the key points of each scenario.
module tb_sort_mem_responder;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          rd_en [N];
    logic          wr_en [N];
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdata [N];
    logic          host_en [N];
    logic          host_we [N];
    logic [AW-1:0] host_addr [N];
    logic [DW-1:0] host_wdata [N];
    logic          vrd [N];
    logic          vwr [N];
    logic [DW-1:0] rd_data [N];
    logic          busy [N];
    logic          req_err [N];
    logic [DW-1:0] host_rdata [N];
`ifdef SORT_MEM_ACC_CNT_EN
    logic [15:0]   rd_cnt [N];
    logic [15:0]   wr_cnt [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        sort_mem_responder #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_rd_en     (rd_en[g]),
            .i_wr_en     (wr_en[g]),
            .i_addr      (addr[g]),
            .i_wr_data   (wdata[g]),
            .o_valid_rd  (vrd[g]),
            .o_valid_wr  (vwr[g]),
            .o_rd_data   (rd_data[g]),
            .o_busy      (busy[g]),
            .o_req_err   (req_err[g]),
            .i_host_en   (host_en[g]),
            .i_host_we   (host_we[g]),
            .i_host_addr (host_addr[g]),
            .i_host_wdata(host_wdata[g]),
`ifdef SORT_MEM_ACC_CNT_EN
            .o_rd_cnt    (rd_cnt[g]),
            .o_wr_cnt    (wr_cnt[g]),
`endif
            .o_host_rdata(host_rdata[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got=%h expected=%h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    // Transaction model: a request sampled at edge n completes (commit + pulse)
    // at edge n+L-1, so the pulse is visible when sampled at edge n+L; the block
    // is free again at the first edge >= n+L+1 with both enables low.
    int            cyc = 0;
    logic [DW-1:0] m_mem [N][16];
    bit            m_free [N];
    int            m_resp_at [N];
    bit            m_wr [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    bit            m_err [N];
    logic [DW-1:0] m_rd [N];
    logic [DW-1:0] m_hr [N];
    int            m_rdcnt [N];
    int            m_wrcnt [N];
    bit            e_vrd [N];
    bit            e_vwr [N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_free[k]    = 1'b1;
            m_resp_at[k] = -100;
            m_err[k]     = 1'b0;
            m_rd[k]      = '0;
            m_hr[k]      = '0;
            m_rdcnt[k]   = 0;
            m_wrcnt[k]   = 0;
            e_vrd[k]     = 1'b0;
            e_vwr[k]     = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge rst_n);
            model_reset();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                if (rst_n) begin
                    e_vrd[k] = 1'b0;
                    e_vwr[k] = 1'b0;
                    if (m_free[k]) begin
                        if (rd_en[k] || wr_en[k]) begin
                            m_free[k]    = 1'b0;
                            m_wr[k]      = wr_en[k];
                            m_addr[k]    = addr[k];
                            m_data[k]    = wdata[k];
                            m_resp_at[k] = cyc + lat(k) - 1;
                            if (rd_en[k] && wr_en[k]) m_err[k] = 1'b1;
                        end else if (host_en[k]) begin
                            if (host_we[k]) m_mem[k][host_addr[k]] = host_wdata[k];
                            else            m_hr[k] = m_mem[k][host_addr[k]];
                        end
                    end else if (cyc >= m_resp_at[k] + 2 && !rd_en[k] && !wr_en[k]) begin
                        m_free[k] = 1'b1;
                    end
                    if (!m_free[k] && cyc == m_resp_at[k]) begin
                        if (m_wr[k]) begin
                            m_mem[k][m_addr[k]] = m_data[k];
                            e_vwr[k] = 1'b1;
                            if (m_wrcnt[k] < 65535) m_wrcnt[k]++;
                        end else begin
                            m_rd[k] = m_mem[k][m_addr[k]];
                            e_vrd[k] = 1'b1;
                            if (m_rdcnt[k] < 65535) m_rdcnt[k]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("m_valid_rd",   k, 32'(vrd[k]),        32'(e_vrd[k]));
                chk("m_valid_wr",   k, 32'(vwr[k]),        32'(e_vwr[k]));
                chk("m_busy",       k, 32'(busy[k]),       32'(!m_free[k]));
                chk("m_req_err",    k, 32'(req_err[k]),    32'(m_err[k]));
                chk("m_rd_data",    k, 32'(rd_data[k]),    32'(m_rd[k]));
                chk("m_host_rdata", k, 32'(host_rdata[k]), 32'(m_hr[k]));
`ifdef SORT_MEM_ACC_CNT_EN
                chk("m_rd_cnt",     k, 32'(rd_cnt[k]),     32'(m_rdcnt[k]));
                chk("m_wr_cnt",     k, 32'(wr_cnt[k]),     32'(m_wrcnt[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input int k, input logic [AW-1:0] a);
        host_en[k] = 1'b1; host_we[k] = 1'b0; host_addr[k] = a;
        tick();
        host_en[k] = 1'b0;
    endtask

    task automatic host_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_en[k] = 1'b1; host_we[k] = 1'b1; host_addr[k] = a; host_wdata[k] = d;
        tick();
        host_en[k] = 1'b0; host_we[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            rd_en[k] = 1'b0; wr_en[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            host_en[k] = 1'b0; host_we[k] = 1'b0; host_addr[k] = '0; host_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk("lit_rst_busy",    k, 32'(busy[k]),       32'd0);
            chk("lit_rst_vrd",     k, 32'(vrd[k]),        32'd0);
            chk("lit_rst_err",     k, 32'(req_err[k]),    32'd0);
            chk("lit_rst_rd_data", k, 32'(rd_data[k]),    32'd0);
            chk("lit_rst_host_rd", k, 32'(host_rdata[k]), 32'd0);
        end

        // Preload every word with 0x30+addr in all instances.
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < N; k++) begin
                host_en[k] = 1'b1; host_we[k] = 1'b1;
                host_addr[k] = AW'(a); host_wdata[k] = DW'(8'h30 + a);
            end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            host_en[k] = 1'b0; host_we[k] = 1'b0;
        end
        tick();

        // Basic write then read, LATENCY=2.
        host_write(0, 4'd3, 8'h5A);
        rd_en[0] = 1'b1; addr[0] = 4'd3;
        tick();
        chk("lit_basic_busy0", 0, 32'(busy[0]), 32'd1);
        chk("lit_basic_vrd0",  0, 32'(vrd[0]),  32'd0);
        tick();
        chk("lit_basic_vrd1",  0, 32'(vrd[0]),  32'd1);
        chk("lit_basic_data",  0, 32'(rd_data[0]), 32'h5A);
        rd_en[0] = 1'b0;
        tick();
        chk("lit_basic_busy2", 0, 32'(busy[0]), 32'd1);
        chk("lit_basic_vrd2",  0, 32'(vrd[0]),  32'd0);
        tick();
        chk("lit_basic_idle",  0, 32'(busy[0]), 32'd0);

        // Held enable: four extra cycles after the pulse, one pulse only.
        rd_en[0] = 1'b1; addr[0] = 4'd4;
        tick();
        tick();
        chk("lit_held_vrd", 0, 32'(vrd[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lit_held_novrd", 0, 32'(vrd[0]),  32'd0);
            chk("lit_held_busy",  0, 32'(busy[0]), 32'd1);
        end
        rd_en[0] = 1'b0;
        tick();
        chk("lit_held_idle", 0, 32'(busy[0]), 32'd0);

        // Write commit with address/data changing during BUSY.
        wr_en[0] = 1'b1; addr[0] = 4'd7; wdata[0] = 8'hC3;
        tick();
        addr[0] = 4'd2; wdata[0] = 8'h99;
        tick();
        chk("lit_wr_vwr", 0, 32'(vwr[0]), 32'd1);
        chk("lit_wr_vrd", 0, 32'(vrd[0]), 32'd0);
        wr_en[0] = 1'b0;
        tick();
        tick();
        host_read(0, 4'd7);
        chk("lit_wr_mem7", 0, 32'(host_rdata[0]), 32'hC3);
        host_read(0, 4'd2);
        chk("lit_wr_mem2", 0, 32'(host_rdata[0]), 32'h32);

        // Collision at LATENCY=1: write wins, sticky error.
        rd_en[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 4'd1; wdata[1] = 8'h11;
        tick();
        chk("lit_col_vwr", 1, 32'(vwr[1]),     32'd1);
        chk("lit_col_vrd", 1, 32'(vrd[1]),     32'd0);
        chk("lit_col_err", 1, 32'(req_err[1]), 32'd1);
        rd_en[1] = 1'b0; wr_en[1] = 1'b0;
        tick();
        tick();
        host_read(1, 4'd1);
        chk("lit_col_mem1", 1, 32'(host_rdata[1]), 32'h11);

        // Host write ignored while busy.
        rd_en[0] = 1'b1; addr[0] = 4'd5;
        tick();
        host_en[0] = 1'b1; host_we[0] = 1'b1; host_addr[0] = 4'd0; host_wdata[0] = 8'hFF;
        tick();
        host_en[0] = 1'b0; host_we[0] = 1'b0;
        rd_en[0] = 1'b0;
        tick();
        tick();
        host_read(0, 4'd0);
        chk("lit_hblk_mem0", 0, 32'(host_rdata[0]), 32'h30);
        // The same host write in IDLE takes effect (LATENCY=1 instance).
        host_write(1, 4'd0, 8'hFF);
        host_read(1, 4'd0);
        chk("lit_hidle_mem0", 1, 32'(host_rdata[1]), 32'hFF);
        chk("lit_err_sticky", 1, 32'(req_err[1]),    32'd1);

        // LATENCY=4 read: pulse exactly four edges after sampling.
        rd_en[2] = 1'b1; addr[2] = 4'd4;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_l4_novrd", 2, 32'(vrd[2]), 32'(i == 2));
        end
        chk("lit_l4_data", 2, 32'(rd_data[2]), 32'h34);
        rd_en[2] = 1'b0;
        tick();
        tick();

        // Reset in the middle of a LATENCY=4 write.
        wr_en[2] = 1'b1; addr[2] = 4'd9; wdata[2] = 8'hEE;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("lit_mrst_busy", 2, 32'(busy[2]),    32'd0);
        chk("lit_mrst_vwr",  2, 32'(vwr[2]),     32'd0);
        chk("lit_mrst_data", 2, 32'(rd_data[2]), 32'd0);
        chk("lit_mrst_err1", 1, 32'(req_err[1]), 32'd0);
`ifdef SORT_MEM_ACC_CNT_EN
        chk("lit_mrst_wcnt", 2, 32'(wr_cnt[2]),  32'd0);
`endif
        wr_en[2] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("lit_mrst_novwr", 2, 32'(vwr[2]), 32'd0);
        host_read(2, 4'd9);
        chk("lit_mrst_mem9", 2, 32'(host_rdata[2]), 32'h39);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
